// File: rtl/down_timer_pkg.sv
// rtl/down_timer_pkg.sv - state encoding shared by the down_timer block
package down_timer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/down_count_core.sv
// rtl/down_count_core.sv - loadable non-wrapping down counter with one/zero flags
module down_count_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             decr,
    output logic [WIDTH-1:0] count,
    output logic             is_one,
    output logic             is_zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    assign is_one  = (count == ONE);
    assign is_zero = (count == '0);

    // A decrement request at zero is dropped so the count never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (decr && !is_zero) begin
            count <= count - ONE;
        end
    end

endmodule

// File: rtl/down_timer.sv
// rtl/down_timer.sv - loadable down timer FSM; DOWN_TIMER_AUTORELOAD_EN enables periodic reload
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             decr,
    input  logic             abort,
    output logic [WIDTH-1:0] count_reg,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic             core_load;
    logic [WIDTH-1:0] core_val;
    logic             core_decr;
    logic             is_one;
    logic             is_zero;
    logic             eff_zero;

    down_count_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .load_val (core_val),
        .decr     (core_decr),
        .count    (count_reg),
        .is_one   (is_one),
        .is_zero  (is_zero)
    );

    // A same-cycle load decides whether start runs or finishes immediately.
    assign eff_zero = load ? (load_val == '0) : is_zero;

`ifdef DOWN_TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            reload_reg <= '0;
        end else if (state == IDLE && !abort && load) begin
            reload_reg <= load_val;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        core_load = 1'b0;
        core_val  = load_val;
        core_decr = 1'b0;
        case (state)
            IDLE: begin
                if (!abort) begin
                    core_load = load;
                    if (start) begin
                        state_nxt = eff_zero ? DONE : RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (decr) begin
                    core_decr = 1'b1;
                    if (is_one) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
`ifdef DOWN_TIMER_AUTORELOAD_EN
                if (abort || reload_reg == '0) begin
                    state_nxt = IDLE;
                end else begin
                    core_load = 1'b1;
                    core_val  = reload_reg;
                    state_nxt = RUN;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_down_timer.sv
// tb/tb_down_timer.sv - directed and randomized checks of down_timer against a behavioural model
module tb_down_timer;

`ifdef DOWN_TIMER_AUTORELOAD_EN
    localparam int AR = 1;
`else
    localparam int AR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, load, start, decr, abort;
    logic [7:0] load_val;
    logic [7:0] count_reg;
    logic       busy, done;

    int vectors = 0;
    int errors  = 0;

    // Reference model: phase 0 idle, 1 counting, 2 finished
    int m_cnt = 0;
    int m_rel = 0;
    int m_ph  = 0;

    down_timer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_val  (load_val),
        .start     (start),
        .decr      (decr),
        .abort     (abort),
        .count_reg (count_reg),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit l, input int lv, input bit s,
                              input bit d, input bit a);
        int eff;
        if (r) begin
            m_cnt = 0; m_rel = 0; m_ph = 0;
        end else if (m_ph == 0) begin
            if (!a) begin
                eff = l ? lv : m_cnt;
                if (l) begin m_cnt = lv; m_rel = lv; end
                if (s) m_ph = (eff == 0) ? 2 : 1;
            end
        end else if (m_ph == 1) begin
            if (a) m_ph = 0;
            else if (d && m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_ph = 2;
            end
        end else begin
            if (AR == 1 && !a && m_rel != 0) begin
                m_cnt = m_rel; m_ph = 1;
            end else begin
                m_ph = 0;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit l, input int lv, input bit s,
                         input bit d, input bit a);
        rst = r; load = l; load_val = 8'(lv); start = s; decr = d; abort = a;
        @(posedge clk);
        model_step(r, l, lv, s, d, a);
        #1;
        chk("model_count", count_reg, m_cnt);
        chk("model_busy", busy, (m_ph == 1));
        chk("model_done", done, (m_ph == 2));
    endtask

    int ndone;

    initial begin
        // 1: reset held two cycles
        for (int i = 0; i < 2; i++) begin
            cycle(1, 0, 0, 0, 0, 0);
            chk("rst_count", count_reg, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
        end

        // 2: load 5 + start, decr held
        cycle(0, 1, 5, 1, 1, 0);
        chk("t2_load", count_reg, 5);
        chk("t2_busy", busy, 1);
        for (int i = 1; i <= 5; i++) begin
            cycle(0, 0, 0, 0, 1, 0);
            chk("t2_count", count_reg, 5 - i);
            chk("t2_done", done, (i == 5));
            chk("t2_busy_run", busy, (i < 5));
        end
        cycle(0, 0, 0, 0, 1, 0);
        chk("t2_done_after", done, 0);
        chk("t2_busy_after", busy, AR);
        cycle(1, 0, 0, 0, 0, 0);

        // 3: decr toggled, count holds on decr=0
        cycle(0, 1, 3, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, (i % 2 == 0), 0);
            chk("t3_count", count_reg, 2 - i / 2);
            chk("t3_done", done, (i == 4));
        end
        cycle(1, 0, 0, 0, 0, 0);

        // 4: abort at count 2
        cycle(0, 1, 6, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0);
        chk("t4_pre", count_reg, 2);
        cycle(0, 0, 0, 0, 1, 1);
        chk("t4_count", count_reg, 2);
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("t4_hold", count_reg, 2);
        chk("t4_done2", done, 0);

        // 5: load 0 + start goes straight to done, no wrap
        cycle(0, 1, 0, 1, 1, 0);
        chk("t5_done", done, 1);
        chk("t5_count", count_reg, 0);
        chk("t5_busy", busy, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("t5_nowrap", count_reg, 0);
        chk("t5_done_once", done, 0);

        // 6: reset mid-run, then periodic behaviour
        cycle(0, 1, 6, 1, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("t6_pre", count_reg, 4);
        cycle(1, 0, 0, 0, 1, 0);
        chk("t6_count", count_reg, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        cycle(0, 1, 2, 1, 1, 0);
        ndone = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(0, 0, 0, 0, 1, 0);
            ndone += int'(done);
        end
        chk("t6_ndone", ndone, (AR == 1) ? 3 : 1);
        cycle(1, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 11) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
